// File: rtl/fft_strm_frame_sched.sv
`default_nettype none
// fft_strm_frame_sched: round-robin frame scheduler sharing one streaming FFT core among NCH sources.
// Define FFT_SCHED_STATS_EN to add per-channel 16-bit frame counters on FRAME_CNT.
module fft_strm_frame_sched #(
  parameter int NCH          = 4,
  parameter int FFT_SIZE     = 256,
  parameter int TAG_DEPTH    = 4,
  parameter int REFRESH_WAIT = 64
) (
  input  logic                     CLK,
  input  logic                     NGRST,
  input  logic                     CLKEN,
  input  logic                     RST,
  input  logic [NCH-1:0]           REQ,
  input  logic [NCH-1:0]           INV_CFG,
  input  logic                     REFRESH_REQ,
  input  logic                     FFT_RFS,
  input  logic                     FFT_OUTP_READY,
  input  logic                     FFT_DATAO_VALID,
  output logic [NCH-1:0]           GNT,
  output logic [$clog2(NCH)-1:0]   SEL,
  output logic                     FFT_START,
  output logic                     FFT_INVERSE,
  output logic                     FFT_REFRESH,
  output logic [$clog2(NCH)-1:0]   TAG_OUT,
  output logic                     TAG_VALID,
  output logic                     TAG_ERR,
  output logic                     BUSY
`ifdef FFT_SCHED_STATS_EN
  ,
  output logic [16*NCH-1:0]        FRAME_CNT
`endif
);

  localparam int SW = $clog2(NCH);
  localparam int CW = $clog2(FFT_SIZE);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int DW = $clog2(TAG_DEPTH + 1);
  localparam int WW = $clog2(REFRESH_WAIT + 1);
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(FFT_SIZE - 1);
  localparam logic [WW-1:0] LAST_WAIT   = WW'(REFRESH_WAIT - 1);
  localparam logic [DW-1:0] FIFO_FULL   = DW'(TAG_DEPTH);
  localparam logic [SW-1:0] LAST_CH     = SW'(NCH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STREAM  = 2'd1,
    S_REFRESH = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] sample_cnt;
  logic [WW-1:0] wait_cnt;
  logic [SW-1:0] last_grant;
  logic          refresh_pending;
  logic          tag_loaded;

  logic [SW-1:0] tag_mem [TAG_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [DW-1:0] tag_cnt;

  logic [SW-1:0]  pick;
  logic [SW-1:0]  cand;
  logic           found;
  logic [NCH-1:0] pick_oh;
  logic           can_start;
  logic           at_frame_end;
  logic           grant_now;
  logic           refresh_now;
  logic           pop;
  logic           bypass;
  logic           push;

  // Round-robin search begins one past the most recent grant.
  always_comb begin
    pick  = last_grant;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      cand = SW'((int'(last_grant) + i) % NCH);
      if (!found && REQ[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
  end

  assign can_start    = FFT_RFS & (|REQ) & (tag_cnt != FIFO_FULL) & ~refresh_pending;
  assign at_frame_end = (state == S_STREAM) && (sample_cnt == LAST_SAMPLE);
  assign grant_now    = can_start & ((state == S_IDLE) | at_frame_end);
  assign refresh_now  = (state == S_IDLE) & refresh_pending & (tag_cnt == '0);

  // An OUTP_READY that meets an empty FIFO in the cycle of a new grant takes the new tag directly.
  assign pop    = FFT_OUTP_READY & (tag_cnt != '0);
  assign bypass = grant_now & FFT_OUTP_READY & (tag_cnt == '0);
  assign push   = grant_now & ~bypass;

  assign TAG_VALID = FFT_DATAO_VALID & tag_loaded;
  assign BUSY      = (state != S_IDLE) | (tag_cnt != '0);

  always_ff @(posedge CLK) begin
    if (CLKEN && grant_now) tag_mem[wr_ptr] <= pick;
  end

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      state           <= S_IDLE;
      sample_cnt      <= '0;
      wait_cnt        <= '0;
      last_grant      <= LAST_CH;
      refresh_pending <= 1'b0;
      tag_loaded      <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      tag_cnt         <= '0;
      GNT             <= '0;
      SEL             <= '0;
      FFT_START       <= 1'b0;
      FFT_INVERSE     <= 1'b0;
      FFT_REFRESH     <= 1'b0;
      TAG_OUT         <= '0;
      TAG_ERR         <= 1'b0;
    end else if (RST) begin
      state           <= S_IDLE;
      sample_cnt      <= '0;
      wait_cnt        <= '0;
      last_grant      <= LAST_CH;
      refresh_pending <= 1'b0;
      tag_loaded      <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      tag_cnt         <= '0;
      GNT             <= '0;
      SEL             <= '0;
      FFT_START       <= 1'b0;
      FFT_INVERSE     <= 1'b0;
      FFT_REFRESH     <= 1'b0;
      TAG_OUT         <= '0;
      TAG_ERR         <= 1'b0;
    end else if (CLKEN) begin
      FFT_START       <= 1'b0;
      FFT_REFRESH     <= 1'b0;
      refresh_pending <= REFRESH_REQ | (refresh_pending & ~refresh_now);

      if (grant_now) begin
        GNT         <= pick_oh;
        SEL         <= pick;
        FFT_START   <= 1'b1;
        FFT_INVERSE <= INV_CFG[pick];
        last_grant  <= pick;
        sample_cnt  <= '0;
        state       <= S_STREAM;
      end else begin
        case (state)
          S_IDLE: begin
            if (refresh_now) begin
              FFT_REFRESH <= 1'b1;
              wait_cnt    <= '0;
              state       <= S_REFRESH;
            end
          end
          S_STREAM: begin
            if (at_frame_end) begin
              GNT   <= '0;
              SEL   <= '0;
              state <= S_IDLE;
            end else begin
              sample_cnt <= sample_cnt + CW'(1);
            end
          end
          S_REFRESH: begin
            if (wait_cnt == LAST_WAIT) state <= S_IDLE;
            else                       wait_cnt <= wait_cnt + WW'(1);
          end
          default: state <= S_IDLE;
        endcase
      end

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      tag_cnt <= tag_cnt + DW'(1);
      else if (pop && !push) tag_cnt <= tag_cnt - DW'(1);

      if (pop) begin
        TAG_OUT    <= tag_mem[rd_ptr];
        tag_loaded <= 1'b1;
      end else if (bypass) begin
        TAG_OUT    <= pick;
        tag_loaded <= 1'b1;
      end else if (FFT_OUTP_READY) begin
        TAG_ERR    <= 1'b1;
      end
    end
  end

`ifdef FFT_SCHED_STATS_EN
  logic [SW-1:0] load_ch;
  assign load_ch = pop ? tag_mem[rd_ptr] : pick;

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      FRAME_CNT <= '0;
    end else if (RST) begin
      FRAME_CNT <= '0;
    end else if (CLKEN && (pop || bypass)) begin
      FRAME_CNT[16*load_ch +: 16] <= FRAME_CNT[16*load_ch +: 16] + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_strm_frame_sched.sv
`default_nettype none
// Bench for fft_strm_frame_sched: random stimulus checked against a frame-level reference model
// through start/refresh scoreboards plus per-cycle output comparisons.
module tb_fft_strm_frame_sched;
  localparam int NCH = 4;
  localparam int N   = 16;
  localparam int D   = 2;
  localparam int W   = 8;
  localparam int SW  = 2;

  logic           CLK = 1'b0;
  logic           NGRST = 1'b0;
  logic           CLKEN = 1'b0;
  logic           RST = 1'b0;
  logic [NCH-1:0] REQ = '0;
  logic [NCH-1:0] INV_CFG = '0;
  logic           REFRESH_REQ = 1'b0;
  logic           FFT_RFS = 1'b1;
  logic           FFT_OUTP_READY = 1'b0;
  logic           FFT_DATAO_VALID = 1'b0;
  logic [NCH-1:0] GNT;
  logic [SW-1:0]  SEL;
  logic [SW-1:0]  TAG_OUT;
  logic           FFT_START, FFT_INVERSE, FFT_REFRESH, TAG_VALID, TAG_ERR, BUSY;
`ifdef FFT_SCHED_STATS_EN
  logic [16*NCH-1:0] FRAME_CNT;
`endif

  fft_strm_frame_sched #(
    .NCH(NCH), .FFT_SIZE(N), .TAG_DEPTH(D), .REFRESH_WAIT(W)
  ) dut (
    .CLK(CLK), .NGRST(NGRST), .CLKEN(CLKEN), .RST(RST),
    .REQ(REQ), .INV_CFG(INV_CFG), .REFRESH_REQ(REFRESH_REQ),
    .FFT_RFS(FFT_RFS), .FFT_OUTP_READY(FFT_OUTP_READY), .FFT_DATAO_VALID(FFT_DATAO_VALID),
    .GNT(GNT), .SEL(SEL), .FFT_START(FFT_START), .FFT_INVERSE(FFT_INVERSE),
    .FFT_REFRESH(FFT_REFRESH), .TAG_OUT(TAG_OUT), .TAG_VALID(TAG_VALID),
    .TAG_ERR(TAG_ERR), .BUSY(BUSY)
`ifdef FFT_SCHED_STATS_EN
    , .FRAME_CNT(FRAME_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model: time is counted in enabled edges; frames and refresh windows are timestamps.
  typedef struct { int a; int ch; bit inv; } start_t;
  start_t start_q[$];
  int     refr_q[$];
  int     fifo[$];
  int     a = 0;
  int     k = -1000;
  int     r = -1000;
  int     last_ch = NCH - 1;
  int     tag = 0;
  bit     pending = 0;
  bit     loaded = 0;
  bit     err = 0;
  bit     last_active = 0;

  function automatic void chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (edge %0d, t=%0t)", name, got, exp, a, $time);
    end
  endfunction

  task automatic model_step();
    bit             idle, grant, refr;
    int             ch, idx;
    logic [NCH-1:0] rq, iv;
    rq = REQ;
    iv = INV_CFG;
    if (RST) begin
      fifo.delete();
      k = a - 1000; r = a - 1000;
      last_ch = NCH - 1; tag = 0;
      pending = 0; loaded = 0; err = 0;
      return;
    end
    if (!CLKEN) return;
    a++;
    idle  = (a > k + N) && (a > r + W);
    grant = FFT_RFS && (rq != 0) && (fifo.size() < D) && !pending && (idle || a == k + N);
    refr  = idle && pending && (fifo.size() == 0);
    ch = last_ch;
    if (grant) begin
      for (int i = 1; i <= NCH; i++) begin
        idx = (last_ch + i) % NCH;
        if (rq[idx[SW-1:0]]) begin
          ch = idx;
          break;
        end
      end
    end
    if (FFT_OUTP_READY) begin
      if (fifo.size() > 0) begin
        tag = fifo.pop_front();
        loaded = 1;
        if (grant) fifo.push_back(ch);
      end else if (grant) begin
        tag = ch;
        loaded = 1;
      end else begin
        err = 1;
      end
    end else if (grant) begin
      fifo.push_back(ch);
    end
    if (grant) begin
      start_q.push_back('{a, ch, iv[ch[SW-1:0]]});
      k = a;
      last_ch = ch;
    end
    if (refr) begin
      refr_q.push_back(a);
      r = a;
    end
    pending = REFRESH_REQ || (pending && !refr);
  endtask

  // Monitor: scoreboard pops on START/REFRESH, plus per-cycle level checks.
  initial begin
    start_t s;
    int exp_gnt, exp_sel;
    @(posedge NGRST);
    forever begin
      @(negedge CLK);
      exp_gnt = (a < k + N) ? (1 << last_ch) : 0;
      exp_sel = (a < k + N) ? last_ch : 0;
      chk("gnt", int'(GNT), exp_gnt);
      chk("sel", int'(SEL), exp_sel);
      chk("busy", int'(BUSY), int'((a < k + N) || (a < r + W) || (fifo.size() > 0)));
      chk("tag_err", int'(TAG_ERR), int'(err));
      chk("tag_out", int'(TAG_OUT), tag);
      chk("tag_valid", int'(TAG_VALID), int'(FFT_DATAO_VALID && loaded));
      if (last_active) begin
        if (FFT_START) begin
          if (start_q.size() == 0) chk("start_spurious", int'(FFT_START), 0);
          else begin
            s = start_q.pop_front();
            chk("start_sel", int'(SEL), s.ch);
            chk("start_gnt", int'(GNT), 1 << s.ch);
            chk("start_inv", int'(FFT_INVERSE), int'(s.inv));
          end
        end else if (start_q.size() > 0 && start_q[0].a <= a) begin
          void'(start_q.pop_front());
          chk("start_missing", int'(FFT_START), 1);
        end
        if (FFT_REFRESH) begin
          if (refr_q.size() == 0) chk("refresh_spurious", int'(FFT_REFRESH), 0);
          else void'(refr_q.pop_front());
        end else if (refr_q.size() > 0 && refr_q[0] <= a) begin
          void'(refr_q.pop_front());
          chk("refresh_missing", int'(FFT_REFRESH), 1);
        end
      end
    end
  end

  task automatic drive(int cyc);
    bit nonempty;
    nonempty = fifo.size() > 0;
    FFT_DATAO_VALID = ($urandom_range(0, 1) == 1);
    REFRESH_REQ = 1'b0;
    RST = (cyc == 15) || (cyc == 1000);
    CLKEN = 1'b1;
    FFT_OUTP_READY = 1'b0;
    if (cyc < 20) begin
      REQ = '0;
      FFT_RFS = 1'b1;
      FFT_OUTP_READY = (cyc == 10);
    end else if (cyc < 400) begin
      REQ = 4'b1111;
      INV_CFG = NCH'($urandom);
      FFT_RFS = 1'b1;
      FFT_OUTP_READY = nonempty && ($urandom_range(0, 9) == 0);
      REFRESH_REQ = (cyc == 300);
    end else if (cyc < 600) begin
      REQ = 4'b0100;
      INV_CFG = 4'b0100;
      FFT_RFS = 1'b1;
      FFT_OUTP_READY = nonempty && ($urandom_range(0, 7) == 0);
    end else begin
      REQ = ($urandom_range(0, 5) == 0) ? '0 : NCH'($urandom);
      INV_CFG = NCH'($urandom);
      FFT_RFS = ($urandom_range(0, 3) != 0);
      REFRESH_REQ = ($urandom_range(0, 79) == 0);
      CLKEN = ($urandom_range(0, 9) != 0);
      RST = RST || ($urandom_range(0, 399) == 0);
      FFT_OUTP_READY = nonempty ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
    end
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #2;
    NGRST = 1'b1;
    CLKEN = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge CLK);
      model_step();
      last_active = CLKEN || RST;
      #2;
      drive(cyc);
    end
    @(negedge CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_strm_frame_sched.md
# fft_strm_frame_sched

Frame scheduler that shares one streaming FFT core among up to NCH sample sources. It round-robin arbitrates frame requests and issues the core's START when the core signals ready-for-start (RFS). It steers the input mux and applies each channel's INVERSE setting. It tags every output frame with its source channel and inserts twiddle REFRESH cycles only when the pipeline is drained.

## Interface
Parameters:
- NCH, 4: number of requesting channels (2..8)
- FFT_SIZE, 256: points per frame; equals the core's FFT_SIZE
- TAG_DEPTH, 4: frames allowed in flight (tag FIFO depth, power of 2)
- REFRESH_WAIT, 64: cycles held in REFRESH state after the FFT_REFRESH pulse

Ports:
- CLK  in  1  clock
- NGRST  in  1  async active-low reset
- CLKEN  in  1  clock enable; all state frozen when low
- RST  in  1  sync reset, same effect as NGRST
- REQ  in  NCH  per-channel frame request, level
- INV_CFG  in  NCH  per-channel inverse-transform select
- REFRESH_REQ  in  1  pulse; request twiddle refresh
- FFT_RFS  in  1  core ready-for-start
- FFT_OUTP_READY  in  1  core first-output-sample pulse
- FFT_DATAO_VALID  in  1  core output valid
- GNT  out  NCH  one-hot; channel streaming samples this cycle
- SEL  out  clog2(NCH)  input mux select (binary of GNT)
- FFT_START  out  1  one-cycle start pulse to core
- FFT_INVERSE  out  1  INV_CFG of granted channel, valid with FFT_START
- FFT_REFRESH  out  1  one-cycle refresh pulse to core
- TAG_OUT  out  clog2(NCH)  channel ID of the frame currently leaving the core
- TAG_VALID  out  1  FFT_DATAO_VALID qualified by a valid tag
- TAG_ERR  out  1  sticky; OUTP_READY seen with tag FIFO empty
- BUSY  out  1  high in STREAM or REFRESH or tag FIFO non-empty

All outputs reset to 0.

## Operation
- States: IDLE, STREAM, REFRESH.
- Eligible start: FFT_RFS & |REQ & tag FIFO not full & no refresh pending.
- IDLE, eligible:
  - round-robin pick, starting at last_grant+1 (reset last_grant = NCH-1, so channel 0 wins first);
  - next cycle: FFT_START=1, GNT/SEL set, FFT_INVERSE=INV_CFG[ch];
  - push ch into tag FIFO; enter STREAM with sample count=0.
- STREAM:
  - GNT held FFT_SIZE cycles; the START cycle is sample 0.
  - At count==FFT_SIZE-1: if eligible, the next cycle is a new START (gapless back-to-back, no idle cycle); else GNT clears and state returns to IDLE.
- REQ dropped mid-frame is ignored; a frame is always FFT_SIZE samples.
- Refresh:
  - REFRESH_REQ sets refresh_pending, which blocks new grants.
  - In IDLE with pending set and tag FIFO empty: pulse FFT_REFRESH, clear pending, hold REFRESH for REFRESH_WAIT cycles, then return to IDLE.
  - REFRESH_REQ arriving during REFRESH is re-latched and serviced afterwards.
- Output tagging:
  - FFT_OUTP_READY pops the tag FIFO into TAG_OUT.
  - TAG_VALID = FFT_DATAO_VALID & tag_loaded.
  - Pop with FIFO empty sets TAG_ERR; TAG_OUT keeps its old value.
- Push and pop in the same cycle: count unchanged, no error.
- RST/NGRST mid-frame: return to IDLE; flush FIFO; clear pending, TAG_ERR and last_grant; outputs low next edge.

## Timing
- REQ & FFT_RFS sampled at edge t; FFT_START/GNT registered, high after edge t+1.
- FFT_START width exactly 1 cycle. GNT width FFT_SIZE cycles.
- The core raises RFS FFT_SIZE-3 cycles after START, so back-to-back starts are spaced exactly FFT_SIZE cycles.
- TAG_OUT updates at the edge after FFT_OUTP_READY; TAG_VALID is combinational from FFT_DATAO_VALID.
- FFT_REFRESH occurs no earlier than 1 cycle after the FIFO becomes empty.

## Configuration
- FFT_SCHED_STATS_EN defined: adds a 16-bit wrapping counter per channel, FRAME_CNT[16*NCH-1:0], incremented on each TAG_OUT load for that channel and cleared by reset.
- Undefined: no FRAME_CNT port, no counters; all other behaviour identical.

## Test plan
- Reset: NGRST low then high, FFT_RFS=1, REQ=0 -> all outputs 0, state IDLE, BUSY=0.
- REQ=4'b1111 held with FFT_RFS=1, FFT_SIZE=16 -> START every 16 cycles; GNT sequence 0001,0010,0100,1000,0001; no gap cycles.
- INV_CFG=4'b0100, REQ=4'b0100 -> FFT_INVERSE=1 with START; SEL=2; TAG_OUT=2 after OUTP_READY.
- TAG_DEPTH=2, REQ held, no OUTP_READY -> exactly 2 STARTs, then stall with RFS high; one OUTP_READY -> third START issued.
- REFRESH_REQ mid-frame with 1 frame in flight -> no new START; FFT_REFRESH pulse 1 cycle after that frame's OUTP_READY; grants resume REFRESH_WAIT cycles later.
- OUTP_READY with FIFO empty -> TAG_ERR=1 until RST; RST asserted mid-STREAM -> GNT=0 next cycle, FIFO empty.
